// File: rtl/booth_pkg.sv
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types, Booth op encoding and constants for the
//                iterative radix-2 Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NOP = 2'd0,
      ADD = 2'd1,
      SUB = 2'd2
   } booth_op_t;

   localparam int C_DEFAULT_WIDTH = 16;
   localparam int C_CNT_W         = $clog2(C_DEFAULT_WIDTH + 2);

   // Radix-2 recoding of the multiplier bit pair {Q[0], q_1}
   function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
      booth_op_t op;
      case ({q0, q_1})
         2'b10:   op = SUB;
         2'b01:   op = ADD;
         default: op = NOP;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/booth_seq_mul16_step.sv
// ============================================================================
//  Module      : booth_step
//  Description : One combinational Booth step: add/sub/none of M into A, then
//                arithmetic right shift of {A, Q, q_1} by one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step
   import booth_pkg::*;
#(
   parameter int AW = 17,
   parameter int QW = 16
)
(
   input  logic [AW-1:0] i_a,
   input  logic [QW-1:0] i_q,
   input  logic          i_q1,
   input  logic [AW-1:0] i_m,
   output logic [AW-1:0] o_a,
   output logic [QW-1:0] o_q,
   output logic          o_q1
);

   booth_op_t       w_op;
   logic [AW-1:0]   w_sum;

   always_comb begin
      w_op  = booth_decode(i_q[0], i_q1);
      w_sum = i_a;
      case (w_op)
         SUB:     w_sum = i_a - i_m;
         ADD:     w_sum = i_a + i_m;
         default: w_sum = i_a;
      endcase
   end

   assign o_a  = {w_sum[AW-1], w_sum[AW-1:1]};
   assign o_q  = {w_sum[0], i_q[QW-1:1]};
   assign o_q1 = i_q[0];

endmodule

`default_nettype wire

// File: rtl/booth_seq_mul16.sv
// ============================================================================
//  Module      : booth_seq_mul16
//  Description : Iterative radix-2 Booth multiplier sequencer, one step per
//                clock, valid/ready in and out. Option macro BOOTH_UNSIGNED_EN
//                adds an op_signed port for unsigned multiplies.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_mul16
   import booth_pkg::*;
#(
   parameter int WIDTH = C_DEFAULT_WIDTH
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_UNSIGNED_EN
   input  logic               op_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

`ifdef BOOTH_UNSIGNED_EN
   localparam int AW = WIDTH + 2;
   localparam int QW = WIDTH + 1;
`else
   localparam int AW = WIDTH + 1;
   localparam int QW = WIDTH;
`endif
   localparam int CNT_W = $clog2(WIDTH + 2);

   state_t               r_state;
   logic [AW-1:0]        r_a;
   logic [QW-1:0]        r_q;
   logic                 r_q1;
   logic [AW-1:0]        r_m;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_p;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;

   logic [AW-1:0]        w_a_nxt;
   logic [QW-1:0]        w_q_nxt;
   logic                 w_q1_nxt;
   logic [QW-1:0]        w_q_load;
   logic [AW-1:0]        w_m_load;
   logic [CNT_W-1:0]     w_cnt_load;
   logic [2*WIDTH-1:0]   w_prod;

`ifdef BOOTH_UNSIGNED_EN
   logic                 r_signed;

   // Signed ops run only WIDTH steps, so the sign-extension bit of Q is still
   // unshifted at Q[0] and the product sits one bit higher.
   assign w_q_load   = op_signed ? {a[WIDTH-1], a} : {1'b0, a};
   assign w_m_load   = op_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
   assign w_cnt_load = op_signed ? CNT_W'(WIDTH) : CNT_W'(WIDTH + 1);
   assign w_prod     = r_signed ? {w_a_nxt[WIDTH-1:0], w_q_nxt[QW-1:1]}
                                : {w_a_nxt[WIDTH-2:0], w_q_nxt};
`else
   assign w_q_load   = a;
   assign w_m_load   = {b[WIDTH-1], b};
   assign w_cnt_load = CNT_W'(WIDTH);
   assign w_prod     = {w_a_nxt[WIDTH-1:0], w_q_nxt};
`endif

   booth_step #(
      .AW (AW),
      .QW (QW)
   ) u_step (
      .i_a  (r_a),
      .i_q  (r_q),
      .i_q1 (r_q1),
      .i_m  (r_m),
      .o_a  (w_a_nxt),
      .o_q  (w_q_nxt),
      .o_q1 (w_q1_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_q         <= '0;
         r_q1        <= 1'b0;
         r_m         <= '0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
         r_signed    <= 1'b1;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= '0;
                  r_q        <= w_q_load;
                  r_q1       <= 1'b0;
                  r_m        <= w_m_load;
                  r_cnt      <= w_cnt_load;
`ifdef BOOTH_UNSIGNED_EN
                  r_signed   <= op_signed;
`endif
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            RUN: begin
               r_a   <= w_a_nxt;
               r_q   <= w_q_nxt;
               r_q1  <= w_q1_nxt;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_p         <= w_prod;
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign p         = r_p;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mul16.sv
// ============================================================================
//  Module      : tb_booth_seq_mul16
//  Description : Self-checking bench for booth_seq_mul16 (signed build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_mul16;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] op_a      = '0;
   logic [15:0] op_b      = '0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [31:0] p;

   int          total = 0;
   int          bad   = 0;
   longint      t_accept = 0;
   longint      t_prev   = 0;

   always #5 clk = ~clk;

   booth_seq_mul16 #(.WIDTH(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (op_a),
      .b         (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed integer multiply of the two operands
   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      longint sx;
      longint sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 32'(sx * sy);
   endfunction

   task automatic mul(input logic [15:0] xa, input logic [15:0] xb,
                      input int hold, input bit noise);
      logic [31:0] exp;
      logic [31:0] held;
      int          cyc;
      exp      = ref_mul(xa, xb);
      op_a     = xa;
      op_b     = xb;
      in_valid = 1'b1;
      @(posedge clk);
      t_prev   = t_accept;
      t_accept = $time;
      #1;
      in_valid = 1'b0;
      op_a     = 16'($urandom);
      op_b     = 16'($urandom);
      check("busy_after_accept", 32'(busy), 32'd1);
      check("in_ready_after_accept", 32'(in_ready), 32'd0);
      cyc = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (noise) begin
            in_valid = 1'($urandom);
            op_a     = 16'($urandom);
            op_b     = 16'($urandom);
         end
         if (out_valid) break;
      end
      check("latency", 32'(cyc), 32'd16);
      check("product", p, exp);
      if (hold > 0) begin
         out_ready = 1'b0;
         held      = p;
         repeat (hold) begin
            @(posedge clk);
            #1;
            if (noise) in_valid = 1'b1;
         end
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_p", p, held);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("out_valid_after_xfer", 32'(out_valid), 32'd0);
      check("in_ready_after_xfer", 32'(in_ready), 32'd1);
      check("p_after_xfer", p, exp);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_p", p, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      mul(16'd3, 16'd5, 0, 1'b0);
      check("3x5_const", p, 32'h0000_000F);
      mul(16'hFFFF, 16'hFFFF, 0, 1'b1);
      check("m1xm1_const", p, 32'h0000_0001);
      mul(16'h8000, 16'h8000, 0, 1'b0);
      check("min_x_min_const", p, 32'h4000_0000);
      mul(16'h8000, 16'h7FFF, 10, 1'b1);
      check("min_x_max_const", p, 32'hC000_8000);

      // Asynchronous reset partway through a multiply
      op_a     = 16'd1234;
      op_b     = 16'hFFB3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
      check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
      check("midrun_rst_busy", 32'(busy), 32'd0);
      check("midrun_rst_p", p, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mul(16'd2, 16'd3, 0, 1'b0);
      check("2x3_const", p, 32'h0000_0006);

      // Back-to-back random pairs, first one the most-negative corner
      for (int i = 0; i < 1000; i++) begin
         if (i == 0) mul(16'h8000, 16'h8000, 0, 1'b0);
         else        mul(16'($urandom), 16'($urandom), 0, 1'b0);
         if (i > 0) check("throughput", 32'(t_accept - t_prev), 32'd180);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
